fifo_ram_ctrl: RTL and testbench

FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ptr.sv | 24 ++
 rtl/fifo_ram_ctrl.sv | 95 +++++++++
 tb/tb_fifo_ram_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO sizing: default data/address widths and derived RAM depth.
package fifo_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM pointer: increments modulo 2**ADDR_W when en is high, 1-cycle update.
// No backpressure of its own; the parent decides when to advance it.
module fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller driving an external 1-cycle registered-read RAM; dout valid 1 cycle after pop.
// Pushes while full and pops while empty are dropped and flagged with a one-cycle pulse.
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);
  localparam int              DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   count_q, count_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Gated with rst so the RAM sees no traffic in the reset cycle.
  assign push_ok = push && !full  && !rst;
  assign pop_ok  = pop  && !empty && !rst;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop_ok),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    dout_valid_d = pop_ok;
    overflow_d   = push && full;
    underflow_d  = pop && empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign count       = count_q;
  assign dout_valid  = dout_valid_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign dout        = ram_rd_data;
  assign ram_wr_en   = push_ok;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = push_data;
  assign ram_rd_en   = pop_ok;
  assign ram_rd_addr = rd_ptr;
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: queue-based reference model, RAM model, and a dout scoreboard.
module tb_fifo_ram_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic          full, empty, dout_valid, overflow, underflow;
  logic [AW:0]   count;
  logic [DW-1:0] dout;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data = '0;

  fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, pointers as push/pop totals mod DEPTH.
  logic [DW-1:0] model_q [$];
  int            wr_m = 0, rd_m = 0;
  logic          exp_ov = 1'b0, exp_un = 1'b0;

  // Scoreboard shared with the monitor.
  logic [DW-1:0] exp_q [$];
  logic          exp_dv = 1'b0;
  logic          started = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("dout_valid", 32'(dout_valid), 32'(exp_dv));
      if (dout_valid && exp_dv) begin
        if (exp_q.size() == 0) chk("scoreboard_underrun", 32'(1), 32'(0));
        else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input logic r, input logic ps, input logic [DW-1:0] d, input logic pp);
    logic acc_push, acc_pop;
    logic [DW-1:0] head;
    rst = r; push = ps; push_data = d; pop = pp;
    acc_push = !r && ps && (model_q.size() < DEPTH);
    acc_pop  = !r && pp && (model_q.size() > 0);
    head = (model_q.size() > 0) ? model_q[0] : '0;
    #1;
    if (started) begin
      chk("ram_wr_en", 32'(ram_wr_en), 32'(acc_push));
      chk("ram_rd_en", 32'(ram_rd_en), 32'(acc_pop));
      if (!r) begin
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_m));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_m));
        if (acc_push) chk("ram_wr_data", 32'(ram_wr_data), 32'(d));
      end
    end
    @(posedge clk);
    if (r) begin
      model_q.delete();
      exp_q.delete();
      wr_m = 0; rd_m = 0;
      exp_ov = 1'b0; exp_un = 1'b0; exp_dv = 1'b0;
    end else begin
      exp_ov = ps && (model_q.size() == DEPTH);
      exp_un = pp && (model_q.size() == 0);
      if (acc_pop) begin
        void'(model_q.pop_front());
        exp_q.push_back(head);
        rd_m = (rd_m + 1) % DEPTH;
      end
      if (acc_push) begin
        model_q.push_back(d);
        wr_m = (wr_m + 1) % DEPTH;
      end
      exp_dv = acc_pop;
    end
    started = 1'b1;
    @(negedge clk);
    chk("count", 32'(count), 32'(model_q.size()));
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("underflow", 32'(underflow), 32'(exp_un));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    idle();

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    chk("full_after_16", 32'(full), 32'(1));
    step(1'b0, 1'b1, 8'h99, 1'b0);
    idle();

    // Drain in order, then one rejected pop.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, 1'b1);
    idle();
    step(1'b0, 1'b0, '0, 1'b1);
    idle();

    // Half full, then concurrent push+pop so both pointers wrap.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);
    chk("count_steady_8", 32'(count), 32'(8));

    // push+pop at full, then drain and push+pop at empty.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    chk("count_full_pp", 32'(count), 32'(15));
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0, 1'b1);
    idle();
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    chk("count_empty_pp", 32'(count), 32'(1));
    step(1'b0, 1'b0, '0, 1'b1);
    idle();

    // Reset mid-operation with a pop just accepted.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h44, 1'b1);
    chk("post_rst_empty", 32'(empty), 32'(1));
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    idle();

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
           8'($urandom), ($urandom_range(0, 99) < 50));
    end
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
